// File: rtl/mul_div_unit_pkg.sv
// Shared XALU definitions: op codes and the default multi-cycle latencies.
package mul_div_unit_pkg;

  typedef enum logic [3:0] {
    XALU_NOP   = 4'd0,
    XALU_MULT  = 4'd1,
    XALU_MULTU = 4'd2,
    XALU_DIV   = 4'd3,
    XALU_DIVU  = 4'd4,
    XALU_MTHI  = 4'd5,
    XALU_MTLO  = 4'd6,
    XALU_MFHI  = 4'd7,
    XALU_MFLO  = 4'd8
  } xaluop_t;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mul_div_unit_if.sv
// E-stage XALU request/response bundle: issue, operands, busy, HI/LO and the MFHI/MFLO read port.
interface mul_div_unit_if;
  import mul_div_unit_pkg::*;

  logic        start;
  xaluop_t     xaluop;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] out;

  modport master (output start, xaluop, a, b, input busy, hi, lo, out);
  modport slave  (input start, xaluop, a, b, output busy, hi, lo, out);

endinterface

// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit with HI/LO registers and modelled MULT/DIV latency.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input logic            clk,
  input logic            reset,
  mul_div_unit_if.slave  bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  logic [0:0]  state;
  logic [3:0]  count;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_we;

  logic        is_long;
  logic [3:0]  load;
  logic [31:0] res_hi, res_lo;
  logic        res_we;
  logic [63:0] prod;
  logic [31:0] a_mag, b_mag, q_mag, r_mag;

  // Signed divide runs on magnitudes so INT_MIN / -1 wraps to INT_MIN without relying on signed overflow.
  always_comb begin
    is_long = 1'b0;
    load    = '0;
    res_hi  = '0;
    res_lo  = '0;
    res_we  = 1'b0;
    prod    = '0;
    a_mag   = bus.a;
    b_mag   = bus.b;
    q_mag   = '0;
    r_mag   = '0;
    case (bus.xaluop)
      XALU_MULT, XALU_MULTU: begin
        is_long = 1'b1;
        load    = MULT_LOAD;
        res_we  = 1'b1;
        if (bus.xaluop == XALU_MULT)
          prod = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
        else
          prod = {32'd0, bus.a} * {32'd0, bus.b};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      XALU_DIV, XALU_DIVU: begin
        is_long = 1'b1;
        load    = DIV_LOAD;
        res_we  = (bus.b != '0);
        if (bus.xaluop == XALU_DIV) begin
          a_mag = bus.a[31] ? 32'd0 - bus.a : bus.a;
          b_mag = bus.b[31] ? 32'd0 - bus.b : bus.b;
        end
        if (res_we) begin
          q_mag = a_mag / b_mag;
          r_mag = a_mag % b_mag;
        end
        if (bus.xaluop == XALU_DIV) begin
          res_lo = (bus.a[31] ^ bus.b[31]) ? 32'd0 - q_mag : q_mag;
          res_hi = bus.a[31] ? 32'd0 - r_mag : r_mag;
        end else begin
          res_lo = q_mag;
          res_hi = r_mag;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (bus.start) begin
        if (is_long) begin
          pend_hi <= res_hi;
          pend_lo <= res_lo;
          pend_we <= res_we;
          count   <= load;
          busy_q  <= 1'b1;
          state   <= ST_BUSY;
        end else if (bus.xaluop == XALU_MTHI) begin
          hi_q <= bus.a;
        end else if (bus.xaluop == XALU_MTLO) begin
          lo_q <= bus.a;
        end
      end
    end else begin
      if (count == '0) begin
        if (pend_we) begin
          hi_q <= pend_hi;
          lo_q <= pend_lo;
        end
        busy_q <= 1'b0;
        state  <= ST_IDLE;
      end else begin
        count <= count - 4'd1;
      end
    end
  end

  assign bus.busy = busy_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.out  = (bus.xaluop == XALU_MFHI) ? hi_q :
                    (bus.xaluop == XALU_MFLO) ? lo_q : '0;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: latency, HI/LO results, MT/MF ops, ignored issue and reset abort.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cyc;

  mul_div_unit_if bus ();

  mul_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input xaluop_t op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.xaluop = op;
    bus.a      = a;
    bus.b      = b;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.xaluop = XALU_NOP;
  endtask

  // Counts busy cycles at negedges; optionally drives a stray MULT (and new operands) at cycle inject_at.
  task automatic run_busy(input int inject_at, output int cycles);
    cycles = 0;
    for (int guard = 0; guard < 64; guard++) begin
      @(negedge clk);
      if (!bus.busy) break;
      cycles++;
      if (cycles == inject_at) begin
        bus.start  = 1'b1;
        bus.xaluop = XALU_MULT;
        bus.a      = 32'd100;
        bus.b      = 32'd100;
      end else begin
        bus.start  = 1'b0;
        bus.xaluop = XALU_NOP;
      end
    end
    bus.start  = 1'b0;
    bus.xaluop = XALU_NOP;
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.xaluop = XALU_NOP;
    bus.a      = '0;
    bus.b      = '0;
    #12;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    issue(XALU_MULT, 32'hFFFF_FFFD, 32'd7);
    run_busy(0, cyc);
    check("mult_cycles", cyc, 32'd5);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFEB);

    issue(XALU_MULTU, 32'hFFFF_FFFF, 32'd2);
    run_busy(0, cyc);
    check("multu_cycles", cyc, 32'd5);
    check("multu_hi", bus.hi, 32'd1);
    check("multu_lo", bus.lo, 32'hFFFF_FFFE);

    issue(XALU_DIV, 32'hFFFF_FFF9, 32'd2);
    run_busy(0, cyc);
    check("div_cycles", cyc, 32'd10);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);

    issue(XALU_DIVU, 32'd7, 32'd2);
    run_busy(0, cyc);
    check("divu_lo", bus.lo, 32'd3);
    check("divu_hi", bus.hi, 32'd1);

    issue(XALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_busy(0, cyc);
    check("divovf_lo", bus.lo, 32'h8000_0000);
    check("divovf_hi", bus.hi, 32'd0);

    issue(XALU_MTHI, 32'h11, 32'd0);
    @(negedge clk);
    check("mthi_busy", {31'd0, bus.busy}, 32'd0);
    issue(XALU_MTLO, 32'h22, 32'd0);
    @(negedge clk);
    check("mtlo_busy", {31'd0, bus.busy}, 32'd0);
    check("mthi_hi", bus.hi, 32'h11);
    check("mtlo_lo", bus.lo, 32'h22);

    issue(XALU_DIV, 32'd5, 32'd0);
    run_busy(0, cyc);
    check("div0_cycles", cyc, 32'd10);
    check("div0_hi", bus.hi, 32'h11);
    check("div0_lo", bus.lo, 32'h22);

    issue(XALU_MTHI, 32'hABCD, 32'd0);
    bus.xaluop = XALU_MFHI;
    bus.start  = 1'b1;
    @(negedge clk);
    check("mfhi_out", bus.out, 32'hABCD);
    check("mfhi_busy", {31'd0, bus.busy}, 32'd0);
    bus.xaluop = XALU_MFLO;
    @(negedge clk);
    check("mflo_out", bus.out, 32'h22);
    check("mflo_hi", bus.hi, 32'hABCD);
    bus.xaluop = XALU_NOP;
    bus.start  = 1'b0;
    #1;
    check("nop_out", bus.out, 32'd0);

    issue(XALU_MULT, 32'd3, 32'd4);
    bus.a = 32'd9;
    bus.b = 32'd9;
    run_busy(2, cyc);
    check("ign_cycles", cyc, 32'd5);
    check("ign_hi", bus.hi, 32'd0);
    check("ign_lo", bus.lo, 32'd12);
    @(negedge clk);
    check("ign_idle", {31'd0, bus.busy}, 32'd0);

    issue(XALU_DIV, 32'd7, 32'd2);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("post_busy", {31'd0, bus.busy}, 32'd0);
    check("post_hi", bus.hi, 32'd0);
    check("post_lo", bus.lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
